// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_e : fetch FSM state (StRun, StHalted)
//   InstrWidth    : instruction word width
//   AddrWidth     : byte-address / PC width
//   HaltWord      : word that marks end of program when halt-on-zero is built in
package fetch_pkg;

  localparam int unsigned InstrWidth = 32;
  localparam int unsigned AddrWidth  = 64;

  localparam logic [InstrWidth-1:0] HaltWord = 32'h0000_0000;

  typedef enum logic [0:0] {
    StRun    = 1'b0,
    StHalted = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program-counter register for the fetch stage.
// Ports:
//   clk_i      : clock, rising edge
//   reset_i    : synchronous active-high reset, loads RESET_PC
//   load_i     : redirect; loads target_i with the two low bits cleared
//   target_i   : redirect target byte address
//   incr_i     : advance by PC_STEP (64-bit wrap-around)
//   pc_o       : current PC
// With neither load_i nor incr_i asserted the PC holds.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [AddrWidth-1:0] RESET_PC = 64'h0,
  parameter int unsigned          PC_STEP  = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 load_i,
  input  logic [AddrWidth-1:0] target_i,
  input  logic                 incr_i,
  output logic [AddrWidth-1:0] pc_o
);

  localparam logic [AddrWidth-1:0] AlignMask = ~64'h3;

  logic [AddrWidth-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i & AlignMask;
    end else if (incr_i) begin
      pc_d = pc_q + 64'(PC_STEP);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction
// memory and registers the returned word into the IF/ID register with a
// valid/ready handshake toward decode. Redirects from branch resolution flush
// IF/ID and reload the PC.
// Ports:
//   clk_i, reset_i          : clock, synchronous active-high reset
//   imem_address_o          : byte address to instruction memory (= PC)
//   imem_data_i             : instruction word for imem_address_o
//   redirect_valid_i/target : taken branch/jump and its target
//   id_ready_i              : decode accepts IF/ID this cycle
//   id_valid_o/pc/instr     : IF/ID register contents
//   halted_o                : fetch is stopped
//   fault_o                 : sticky out-of-range fetch flag, cleared only by reset
// Build option: define FETCH_HALT_ON_ZERO_EN to stop fetching on an all-zero word
// (zero-filled memory marks end of program) instead of passing it to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [AddrWidth-1:0] RESET_PC = 64'h0,
  parameter int unsigned          PC_STEP  = 4,
  parameter int unsigned          MEM_SIZE = 2048
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  output logic [AddrWidth-1:0]  imem_address_o,
  input  logic [InstrWidth-1:0] imem_data_i,
  input  logic                  redirect_valid_i,
  input  logic [AddrWidth-1:0]  redirect_target_i,
  input  logic                  id_ready_i,
  output logic                  id_valid_o,
  output logic [AddrWidth-1:0]  id_pc_o,
  output logic [InstrWidth-1:0] id_instruction_o,
  output logic                  halted_o,
  output logic                  fault_o
);

  localparam logic [AddrWidth-1:0] MaxPc = 64'(MEM_SIZE - 4);

  fetch_state_e state_d, state_q;

  logic [AddrWidth-1:0]  pc;
  logic                  id_valid_d, id_valid_q;
  logic [AddrWidth-1:0]  id_pc_d, id_pc_q;
  logic [InstrWidth-1:0] id_instr_d, id_instr_q;
  logic                  fault_d, fault_q;

  logic fetch_elig;
  logic out_of_range;
  logic zero_hit;
  logic capture;

  // A fetch is eligible when running, IF/ID is free or draining, and no
  // redirect is pending (redirect overrides everything this cycle).
  assign fetch_elig   = (state_q == StRun) && (!id_valid_q || id_ready_i) && !redirect_valid_i;
  assign out_of_range = pc > MaxPc;

`ifdef FETCH_HALT_ON_ZERO_EN
  assign zero_hit = !out_of_range && (imem_data_i == HaltWord);
`else
  assign zero_hit = 1'b0;
`endif

  assign capture = fetch_elig && !out_of_range && !zero_hit;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (redirect_valid_i),
    .target_i (redirect_target_i),
    .incr_i   (capture),
    .pc_o     (pc)
  );

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (redirect_valid_i) begin
      state_d = StRun;
    end else if (fetch_elig && (out_of_range || zero_hit)) begin
      state_d = StHalted;
    end
  end

  // FSM: outputs
  always_comb begin
    halted_o = (state_q == StHalted);
  end

  // IF/ID register and sticky fault
  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    fault_d    = fault_q | (fetch_elig && out_of_range);
    if (redirect_valid_i) begin
      id_valid_d = 1'b0;
    end else if (capture) begin
      id_valid_d = 1'b1;
      id_pc_d    = pc;
      id_instr_d = imem_data_i;
    end else if (id_valid_q && id_ready_i) begin
      // Decode consumed the entry and nothing replaced it.
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_address_o   = pc;
  assign id_valid_o       = id_valid_q;
  assign id_pc_o          = id_pc_q;
  assign id_instruction_o = id_instr_q;
  assign fault_o          = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

`ifdef FETCH_HALT_ON_ZERO_EN
  localparam bit HaltOnZero = 1'b1;
`else
  localparam bit HaltOnZero = 1'b0;
`endif

  localparam logic [31:0] W0   = 32'h8b1f03e5;
  localparam logic [31:0] W1   = 32'hf84000a4;
  localparam logic [31:0] W2   = 32'h1111_1111;
  localparam logic [31:0] W3   = 32'h2222_2222;
  localparam logic [31:0] W4   = 32'h3333_3333;
  localparam logic [31:0] W6   = 32'h4444_4444;
  localparam logic [31:0] WEnd = 32'h5555_5555;
  localparam logic [31:0] Junk = 32'hdead_beef;

  logic        clk;
  logic        reset;
  logic [63:0] imem_address;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        id_ready;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instruction;
  logic        halted;
  logic        fault;

  // Second instance with pipeline-spaced memory (PC_STEP = 16)
  logic        reset16;
  logic [63:0] imem_address16;
  logic [31:0] imem_data16;
  logic        id_ready16;
  logic        id_valid16;
  logic [63:0] id_pc16;
  logic [31:0] id_instruction16;
  logic        halted16;
  logic        fault16;

  logic [31:0] mem   [512];
  logic [31:0] mem16 [512];

  assign imem_data   = (imem_address < 64'd2048) ? mem[imem_address[10:2]] : Junk;
  assign imem_data16 = (imem_address16 < 64'd2048) ? mem16[imem_address16[10:2]] : Junk;

  fetch_unit #(
    .RESET_PC (64'h0),
    .PC_STEP  (4),
    .MEM_SIZE (2048)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .imem_address_o    (imem_address),
    .imem_data_i       (imem_data),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .id_ready_i        (id_ready),
    .id_valid_o        (id_valid),
    .id_pc_o           (id_pc),
    .id_instruction_o  (id_instruction),
    .halted_o          (halted),
    .fault_o           (fault)
  );

  fetch_unit #(
    .RESET_PC (64'h0),
    .PC_STEP  (16),
    .MEM_SIZE (2048)
  ) dut16 (
    .clk_i             (clk),
    .reset_i           (reset16),
    .imem_address_o    (imem_address16),
    .imem_data_i       (imem_data16),
    .redirect_valid_i  (1'b0),
    .redirect_target_i (64'h0),
    .id_ready_i        (id_ready16),
    .id_valid_o        (id_valid16),
    .id_pc_o           (id_pc16),
    .id_instruction_o  (id_instruction16),
    .halted_o          (halted16),
    .fault_o           (fault16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        redir;
    logic [63:0] target;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
    logic [63:0] e_addr;
    logic        e_halted;
    logic        e_fault;
  } vec_t;

  vec_t vecs[16];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic e_valid, input logic [63:0] e_pc,
                           input logic [31:0] e_instr, input logic [63:0] e_addr,
                           input logic e_halted, input logic e_fault);
    check({tag, ".id_valid"}, 64'(id_valid), 64'(e_valid));
    check({tag, ".id_pc"}, id_pc, e_pc);
    check({tag, ".id_instruction"}, 64'(id_instruction), 64'(e_instr));
    check({tag, ".imem_address"}, imem_address, e_addr);
    check({tag, ".halted"}, 64'(halted), 64'(e_halted));
    check({tag, ".fault"}, 64'(fault), 64'(e_fault));
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i]   = Junk;
      mem16[i] = Junk;
    end
    mem[0]   = W0;
    mem[1]   = W1;
    mem[2]   = W2;
    mem[3]   = W3;
    mem[4]   = W4;
    mem[5]   = 32'h0;   // byte address 20
    mem[6]   = W6;
    mem[511] = WEnd;    // byte address 2044
    for (int k = 0; k < 5; k++) mem16[k * 4] = 32'hc000_0000 + 32'(k);

    //            ready redir target       valid pc      instr  addr      halt fault
    vecs[0]  = '{1'b1, 1'b0, 64'h0,      1'b1, 64'd0,  W0,  64'd4,    1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 64'h0,      1'b1, 64'd0,  W0,  64'd4,    1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 64'h0,      1'b1, 64'd0,  W0,  64'd4,    1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 64'h0,      1'b1, 64'd0,  W0,  64'd4,    1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 64'h0,      1'b1, 64'd4,  W1,  64'd8,    1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 64'h0,      1'b1, 64'd8,  W2,  64'd12,   1'b0, 1'b0};
    // redirect while stalled: flush and align 0x13 -> 0x10
    vecs[6]  = '{1'b0, 1'b1, 64'h13,     1'b0, 64'd8,  W2,  64'h10,   1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 64'h0,      1'b1, 64'h10, W4,  64'd20,   1'b0, 1'b0};
    if (HaltOnZero) begin
      vecs[8]  = '{1'b1, 1'b0, 64'h0,    1'b0, 64'd16, W4,  64'd20,   1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 64'h0,    1'b0, 64'd16, W4,  64'd20,   1'b1, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 64'd2046, 1'b0, 64'd16, W4,  64'd2044, 1'b0, 1'b0};
    end else begin
      vecs[8]  = '{1'b1, 1'b0, 64'h0,    1'b1, 64'd20, 32'h0, 64'd24, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 64'h0,    1'b1, 64'd24, W6,  64'd28,   1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 64'd2046, 1'b0, 64'd24, W6,  64'd2044, 1'b0, 1'b0};
    end
    vecs[11] = '{1'b1, 1'b0, 64'h0,      1'b1, 64'd2044, WEnd, 64'd2048, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 64'h0,      1'b0, 64'd2044, WEnd, 64'd2048, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 64'h0,      1'b0, 64'd2044, WEnd, 64'd2048, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 64'h0,      1'b0, 64'd2044, WEnd, 64'd0,    1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 64'h0,      1'b1, 64'd0,  W0,  64'd4,    1'b0, 1'b1};

    reset           = 1'b1;
    reset16         = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 64'h0;
    id_ready        = 1'b0;
    id_ready16      = 1'b1;
    step();
    step();
    check_all("reset", 1'b0, 64'd0, 32'h0, 64'd0, 1'b0, 1'b0);

    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      id_ready        = vecs[i].ready;
      redirect_valid  = vecs[i].redir;
      redirect_target = vecs[i].target;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr,
                vecs[i].e_addr, vecs[i].e_halted, vecs[i].e_fault);
    end
    redirect_valid = 1'b0;

    // Stall, then reset mid-stall: everything (including sticky fault) clears.
    id_ready = 1'b0;
    step();
    check_all("stall_before_reset", 1'b1, 64'd0, W0, 64'd4, 1'b0, 1'b1);
    reset = 1'b1;
    step();
    check_all("reset_mid_stall", 1'b0, 64'd0, 32'h0, 64'd0, 1'b0, 1'b0);
    reset = 1'b0;
    id_ready = 1'b1;
    step();
    check_all("after_reset", 1'b1, 64'd0, W0, 64'd4, 1'b0, 1'b0);

    // PC_STEP = 16 instance: id_pc 0,16,32,48,64
    check("step16.addr0", imem_address16, 64'd0);
    reset16 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("step16.id_pc%0d", k), id_pc16, 64'(k * 16));
      check($sformatf("step16.instr%0d", k), 64'(id_instruction16), 64'(32'hc000_0000 + 32'(k)));
      check($sformatf("step16.valid%0d", k), 64'(id_valid16), 64'd1);
    end
    check("step16.fault", 64'(fault16), 64'd0);
    check("step16.halted", 64'(halted16), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
